led_rgb_blink_core: RTL and testbench

//  Three-channel LED blink engine that drives the Z-turn RGB LED pins.

---
 rtl/led_rgb_blink_core.sv | 119 +++++++++++
 tb/tb_led_rgb_blink_core.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_rgb_blink_core.sv
// Three independent R/G/B LED blink channels sharing one free-running prescaler tick.
// Each channel is OFF / CONST / BLINK / HOLD; pins and status come straight from the lit registers.
module led_rgb_blink_core #(
  parameter int unsigned PRESCALE       = 1,
  parameter bit          LED_ACTIVE_LOW = 1'b0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        user_resetn,
  input  logic        mode_r,
  input  logic        mode_g,
  input  logic        mode_b,
  input  logic        enable_r,
  input  logic        enable_g,
  input  logic        enable_b,
  input  logic        holded_r,
  input  logic        holded_g,
  input  logic        holded_b,
  input  logic [31:0] duration_r,
  input  logic [31:0] duration_g,
  input  logic [31:0] duration_b,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        led_r_sts,
  output logic        led_g_sts,
  output logic        led_b_sts
);

  typedef enum logic [1:0] {OFF, CONST, BLINK, HOLD} state_t;

  logic        rst;
  logic [31:0] pre;
  logic        tick;
  logic [2:0]  mode_v;
  logic [2:0]  en_v;
  logic [2:0]  hold_v;
  logic [31:0] dur_v [3];

  assign rst    = !aresetn || !user_resetn;
  assign mode_v = {mode_b, mode_g, mode_r};
  assign en_v   = {enable_b, enable_g, enable_r};
  assign hold_v = {holded_b, holded_g, holded_r};

  always_comb begin
    dur_v[0] = duration_r;
    dur_v[1] = duration_g;
    dur_v[2] = duration_b;
  end

  assign tick = (pre == 32'(PRESCALE - 1));

  always_ff @(posedge aclk) begin
    if (rst || tick) pre <= '0;
    else             pre <= pre + 32'd1;
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    state_t      st_q, st_d;
    logic        lit_q, lit_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] dur_eff;

    always_comb begin
      dur_eff = (dur_v[c] == '0) ? 32'd1 : dur_v[c];
      st_d    = st_q;
      lit_d   = lit_q;
      cnt_d   = cnt_q;
      if (!en_v[c]) begin
        if (hold_v[c]) begin
          st_d = HOLD;
        end else begin
          st_d  = OFF;
          lit_d = 1'b0;
          cnt_d = '0;
        end
      end else if (!mode_v[c]) begin
        st_d  = CONST;
        lit_d = 1'b1;
        cnt_d = '0;
      end else if (st_q == OFF || st_q == CONST) begin
        st_d  = BLINK;
        lit_d = 1'b1;
        cnt_d = '0;
      end else begin
        // Resuming from HOLD counts the resume cycle's tick, so the frozen phase continues seamlessly.
        st_d = BLINK;
        if (tick) begin
          if (cnt_q >= dur_eff - 32'd1) begin
            lit_d = !lit_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end
    end

    always_ff @(posedge aclk) begin
      if (rst) begin
        st_q  <= OFF;
        lit_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        lit_q <= lit_d;
        cnt_q <= cnt_d;
      end
    end
  end

  assign led_r     = g_ch[0].lit_q ^ LED_ACTIVE_LOW;
  assign led_g     = g_ch[1].lit_q ^ LED_ACTIVE_LOW;
  assign led_b     = g_ch[2].lit_q ^ LED_ACTIVE_LOW;
  assign led_r_sts = g_ch[0].lit_q;
  assign led_g_sts = g_ch[1].lit_q;
  assign led_b_sts = g_ch[2].lit_q;

endmodule

// File: tb/tb_led_rgb_blink_core.sv
// Bench for led_rgb_blink_core: directed scenarios plus randomized run against a phase-level model.
// Instance 0 uses PRESCALE=1 active-high pins, instance 1 PRESCALE=3 active-low pins.
module tb_led_rgb_blink_core;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        user_resetn;
  logic [2:0]  en, md, hd;
  logic [31:0] du [3];
  wire  [2:0]  led0, sts0, led1, sts1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 aclk = ~aclk;

  led_rgb_blink_core #(.PRESCALE(1), .LED_ACTIVE_LOW(1'b0)) dut0 (
    .aclk(aclk), .aresetn(aresetn), .user_resetn(user_resetn),
    .mode_r(md[0]), .mode_g(md[1]), .mode_b(md[2]),
    .enable_r(en[0]), .enable_g(en[1]), .enable_b(en[2]),
    .holded_r(hd[0]), .holded_g(hd[1]), .holded_b(hd[2]),
    .duration_r(du[0]), .duration_g(du[1]), .duration_b(du[2]),
    .led_r(led0[0]), .led_g(led0[1]), .led_b(led0[2]),
    .led_r_sts(sts0[0]), .led_g_sts(sts0[1]), .led_b_sts(sts0[2])
  );

  led_rgb_blink_core #(.PRESCALE(3), .LED_ACTIVE_LOW(1'b1)) dut1 (
    .aclk(aclk), .aresetn(aresetn), .user_resetn(user_resetn),
    .mode_r(md[0]), .mode_g(md[1]), .mode_b(md[2]),
    .enable_r(en[0]), .enable_g(en[1]), .enable_b(en[2]),
    .holded_r(hd[0]), .holded_g(hd[1]), .holded_b(hd[2]),
    .duration_r(du[0]), .duration_g(du[1]), .duration_b(du[2]),
    .led_r(led1[0]), .led_g(led1[1]), .led_b(led1[2]),
    .led_r_sts(sts1[0]), .led_g_sts(sts1[1]), .led_b_sts(sts1[2])
  );

  // Reference model: per channel an activity (0 dark, 1 steady, 2 blinking, 3 frozen),
  // the lit level and the number of ticks already spent in the current half-period.
  localparam int PS [2] = '{1, 3};
  bit     m_lit     [2][3];
  longint m_elapsed [2][3];
  int     m_act     [2][3];
  int     m_pre     [2];
  bit     m_tick;
  longint m_len;

  always @(posedge aclk) begin
    for (int k = 0; k < 2; k++) begin
      m_tick = (m_pre[k] == PS[k] - 1);
      if (!aresetn || !user_resetn) begin
        m_pre[k] = 0;
        for (int c = 0; c < 3; c++) begin
          m_act[k][c] = 0; m_lit[k][c] = 1'b0; m_elapsed[k][c] = 0;
        end
      end else begin
        m_pre[k] = (m_pre[k] + 1) % PS[k];
        for (int c = 0; c < 3; c++) begin
          m_len = (du[c] == 32'd0) ? 64'd1 : longint'(du[c]);
          if (!en[c]) begin
            if (hd[c]) m_act[k][c] = 3;
            else begin m_act[k][c] = 0; m_lit[k][c] = 1'b0; m_elapsed[k][c] = 0; end
          end else if (!md[c]) begin
            m_act[k][c] = 1; m_lit[k][c] = 1'b1; m_elapsed[k][c] = 0;
          end else if (m_act[k][c] < 2) begin
            m_act[k][c] = 2; m_lit[k][c] = 1'b1; m_elapsed[k][c] = 0;
          end else begin
            m_act[k][c] = 2;
            if (m_tick) begin
              if (m_elapsed[k][c] + 1 >= m_len) begin
                m_lit[k][c] = !m_lit[k][c]; m_elapsed[k][c] = 0;
              end else begin
                m_elapsed[k][c] = m_elapsed[k][c] + 1;
              end
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    aresetn = 1'b0; user_resetn = 1'b1;
    en = '1; md = '1; hd = '1;
    for (int c = 0; c < 3; c++) du[c] = 32'd1;
    repeat (2) @(negedge aclk);
    n_checks++; if (led0 !== 3'b000) begin n_fail++; $display("FAIL reset_led0 got %b want 000", led0); end
    n_checks++; if (sts0 !== 3'b000) begin n_fail++; $display("FAIL reset_sts0 got %b want 000", sts0); end
    n_checks++; if (led1 !== 3'b111) begin n_fail++; $display("FAIL reset_led1 got %b want 111", led1); end
    n_checks++; if (sts1 !== 3'b000) begin n_fail++; $display("FAIL reset_sts1 got %b want 000", sts1); end
    aresetn = 1'b1;
    @(negedge aclk);
    n_checks++; if (led0 !== 3'b111) begin n_fail++; $display("FAIL release_led0 got %b want 111", led0); end
    n_checks++; if (led1 !== 3'b000) begin n_fail++; $display("FAIL release_led1 got %b want 000", led1); end
  endtask

  task automatic test_const();
    en = '0; hd = '0; @(negedge aclk);
    en[1] = 1'b1; md[1] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      n_checks++; if (led0[1] !== 1'b1) begin n_fail++; $display("FAIL const_on cyc %0d got %b want 1", i, led0[1]); end
    end
    en[1] = 1'b0; hd[1] = 1'b0;
    @(negedge aclk);
    n_checks++; if (led0[1] !== 1'b0) begin n_fail++; $display("FAIL const_off got %b want 0", led0[1]); end
  endtask

  task automatic test_blink();
    int  last = -1;
    int  ntr  = 0;
    bit  prev;
    en = '0; hd = '0; @(negedge aclk);
    du[2] = 32'd4; md[2] = 1'b1; en[2] = 1'b1;
    prev = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge aclk);
      n_checks++;
      if (led0[2] !== (((i / 4) % 2) == 0)) begin n_fail++; $display("FAIL blink4 cyc %0d got %b want %b", i, led0[2], ((i / 4) % 2) == 0); end
      n_checks++;
      if (led1[2] !== ~sts1[2]) begin n_fail++; $display("FAIL active_low_pin cyc %0d pin %b sts %b", i, led1[2], sts1[2]); end
      if (sts1[2] !== prev) begin
        if (last >= 0) begin
          n_checks++;
          if (i - last != 12) begin n_fail++; $display("FAIL prescale3_phase got %0d want 12", i - last); end
        end
        last = i; prev = sts1[2]; ntr++;
      end
    end
    n_checks++; if (ntr < 4) begin n_fail++; $display("FAIL prescale3_transitions got %0d want >=4", ntr); end
    en[2] = 1'b0; @(negedge aclk);
    du[2] = 32'd0; en[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      n_checks++; if (led0[2] !== ((i % 2) == 0)) begin n_fail++; $display("FAIL blink0 cyc %0d got %b want %b", i, led0[2], (i % 2) == 0); end
    end
  endtask

  task automatic test_hold();
    for (int pass = 0; pass < 2; pass++) begin
      en = '0; hd = '0; @(negedge aclk);
      du[0] = 32'd4; md[0] = 1'b1; en[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
        @(negedge aclk);
        n_checks++; if (led0[0] !== (i < 4)) begin n_fail++; $display("FAIL hold_pre p%0d cyc %0d got %b want %b", pass, i, led0[0], i < 4); end
      end
      en[0] = 1'b0; hd[0] = (pass == 0);
      for (int i = 0; i < 20; i++) begin
        @(negedge aclk);
        n_checks++; if (led0[0] !== 1'b0) begin n_fail++; $display("FAIL hold_idle p%0d cyc %0d got %b want 0", pass, i, led0[0]); end
      end
      en[0] = 1'b1;
      for (int i = 0; i < 7; i++) begin
        bit exp;
        exp = (pass == 0) ? (i >= 2 && i < 6) : (i < 4);
        @(negedge aclk);
        n_checks++; if (led0[0] !== exp) begin n_fail++; $display("FAIL hold_resume p%0d cyc %0d got %b want %b", pass, i, led0[0], exp); end
      end
    end
  endtask

  task automatic test_shrink();
    int changes = 0;
    en = '0; hd = '0; @(negedge aclk);
    du[1] = 32'd100; md[1] = 1'b1; en[1] = 1'b1;
    for (int i = 0; i <= 50; i++) begin
      @(negedge aclk);
      n_checks++; if (led0[1] !== 1'b1) begin n_fail++; $display("FAIL shrink_lit cyc %0d got %b want 1", i, led0[1]); end
    end
    du[1] = 32'd10;
    for (int i = 0; i < 11; i++) begin
      @(negedge aclk);
      n_checks++; if (led0[1] !== (i == 10)) begin n_fail++; $display("FAIL shrink_phase cyc %0d got %b want %b", i, led0[1], i == 10); end
    end
    du[1] = 32'hFFFF_FFFF;
    for (int i = 0; i < 10000; i++) begin
      @(negedge aclk);
      if (led0[1] !== 1'b1) changes++;
    end
    n_checks++; if (changes != 0) begin n_fail++; $display("FAIL max_duration got %0d off cycles want 0", changes); end
  endtask

  task automatic test_soft_reset();
    en = '0; hd = '0; @(negedge aclk);
    for (int c = 0; c < 3; c++) du[c] = 32'd4;
    md = '1; en = '1;
    repeat (2) @(negedge aclk);
    user_resetn = 1'b0;
    @(negedge aclk);
    n_checks++; if (led0 !== 3'b000) begin n_fail++; $display("FAIL soft_rst_led0 got %b want 000", led0); end
    n_checks++; if (sts1 !== 3'b000) begin n_fail++; $display("FAIL soft_rst_sts1 got %b want 000", sts1); end
    n_checks++; if (led1 !== 3'b111) begin n_fail++; $display("FAIL soft_rst_led1 got %b want 111", led1); end
    user_resetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge aclk);
      n_checks++; if (sts0 !== ((i < 4) ? 3'b111 : 3'b000)) begin n_fail++; $display("FAIL soft_rst_restart cyc %0d got %b want %b", i, sts0, (i < 4) ? 3'b111 : 3'b000); end
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 3000; n++) begin
      @(negedge aclk);
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (sts0[c] !== m_lit[0][c] || led0[c] !== m_lit[0][c]) begin
          n_fail++; $display("FAIL rand_p1 cyc %0d ch %0d led %b sts %b want %b", n, c, led0[c], sts0[c], m_lit[0][c]);
        end
        n_checks++;
        if (sts1[c] !== m_lit[1][c] || led1[c] !== !m_lit[1][c]) begin
          n_fail++; $display("FAIL rand_p3 cyc %0d ch %0d led %b sts %b want sts %b", n, c, led1[c], sts1[c], m_lit[1][c]);
        end
      end
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 11) == 0) begin
          en[c] = ($urandom_range(0, 3) != 0);
          md[c] = ($urandom_range(0, 3) != 0);
          hd[c] = 1'($urandom_range(0, 1));
          r = int'($urandom_range(0, 9));
          du[c] = (r < 2) ? 32'd0 : (r == 9) ? 32'hFFFF_FFFF : 32'($urandom_range(1, 6));
        end
      end
      user_resetn = ($urandom_range(0, 150) != 0);
      aresetn     = ($urandom_range(0, 300) != 0);
    end
    aresetn = 1'b1; user_resetn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_const();
    test_blink();
    test_hold();
    test_shrink();
    test_soft_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
